pelican_mac_sequencer: RTL

Control block that drives one Pelican MAC core from a host-side streaming interface. Latches IV, key and message length, issues the IV load, answers the core's key and message-block requests from a small message FIFO, and returns the 128-bit tag over a valid/ready port. It sits between the SoC host logic and the core's `load_iv` / `load_k` / `load_m` / `din` / `dout` / `done` pins, and replaces ad-hoc host sequencing.

---
 rtl/pelican_seq_pkg.sv | 32 +++
 rtl/pelican_mac_sequencer_if.sv | 52 +++++
 rtl/pelican_seq_fifo.sv | 64 ++++++
 rtl/pelican_mac_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pelican_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pelican_seq_pkg                                            |
// | Description : Shared types and default constants for the Pelican MAC     |
// |               sequencer: FSM state enum, core_din source select codes    |
// |               and default widths/depths.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pelican_seq_pkg;

   localparam int c_DEF_W          = 128;
   localparam int c_DEF_LEN_W      = 16;
   localparam int c_DEF_FIFO_DEPTH = 4;
   localparam int c_DEF_TIMEOUT    = 1024;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_IV        = 3'd1,
      S_RUN       = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_OUT       = 3'd4,
      S_ERR       = 3'd5
   } seq_state_t;

   // Source select for the registered core_din value
   localparam logic [1:0] c_DIN_HOLD = 2'd0;
   localparam logic [1:0] c_DIN_IV   = 2'd1;
   localparam logic [1:0] c_DIN_KEY  = 2'd2;
   localparam logic [1:0] c_DIN_FIFO = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pelican_mac_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pelican_mac_sequencer_if                                   |
// | Description : Bundles the host-side (config, message stream, tag) and    |
// |               core-side (load strobes, din/dout, done) signals of the    |
// |               Pelican MAC sequencer.                                     |
// |   modport slave  : the sequencer's view                                  |
// |   modport master : the host + core view                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface pelican_mac_sequencer_if #(
   parameter int W     = 128,
   parameter int LEN_W = 16
);
   // host configuration / status
   logic             start;
   logic [W-1:0]     cfg_iv;
   logic [W-1:0]     cfg_key;
   logic [LEN_W-1:0] cfg_nblk;
   logic             busy;
   logic             err;
   // message stream
   logic [W-1:0]     msg_data;
   logic             msg_valid;
   logic             msg_ready;
   // tag return
   logic [W-1:0]     tag;
   logic             tag_valid;
   logic             tag_ready;
   // core side
   logic             core_rst;
   logic             core_load_iv;
   logic [W-1:0]     core_din;
   logic             core_load_k;
   logic             core_load_m;
   logic [W-1:0]     core_dout;
   logic             core_done;

   modport slave (
      input  start, cfg_iv, cfg_key, cfg_nblk, msg_data, msg_valid, tag_ready,
             core_load_k, core_load_m, core_dout, core_done,
      output busy, err, msg_ready, tag, tag_valid, core_rst, core_load_iv, core_din
   );

   modport master (
      output start, cfg_iv, cfg_key, cfg_nblk, msg_data, msg_valid, tag_ready,
             core_load_k, core_load_m, core_dout, core_done,
      input  busy, err, msg_ready, tag, tag_valid, core_rst, core_load_iv, core_din
   );

endinterface
`default_nettype wire

// File: rtl/pelican_seq_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pelican_seq_fifo                                           |
// | Description : Synchronous FIFO for message blocks. Registered storage,   |
// |               no fall-through (a written word is poppable the next       |
// |               cycle). A push while full is taken only together with a    |
// |               pop. Flush empties it in one cycle.                        |
// |   Ports: clk, rst (async, active high), i_push, i_pop, i_flush,          |
// |          i_wdata, o_rdata (head word), o_full, o_empty                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pelican_seq_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   // One extra pointer bit distinguishes full from empty
   logic [c_AW:0]    r_wptr;
   logic [c_AW:0]    r_rptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                      (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_rdata   = r_mem[r_rptr[c_AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage needs no reset; validity is carried by the pointers
   always_ff @(posedge clk) begin
      if (w_push_ok && !i_flush) begin
         r_mem[r_wptr[c_AW-1:0]] <= i_wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pelican_mac_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pelican_mac_sequencer                                      |
// | Description : Drives one Pelican MAC core from a host stream. Latches    |
// |               key and block count on start, issues the IV load, answers  |
// |               key / message requests one cycle later from a message      |
// |               FIFO and returns the tag over a valid/ready port.          |
// |   Ports: clk, rst (async, active high), bus (pelican_mac_sequencer_if    |
// |          slave modport: start/cfg_*, busy, err, msg_*, tag*, core_*)     |
// |   Optional feature: define PELICAN_SEQ_TIMEOUT_EN to leave WAIT_DONE     |
// |          for ERR after TIMEOUT cycles without core_done.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pelican_mac_sequencer
   import pelican_seq_pkg::*;
#(
   parameter int W          = c_DEF_W,
   parameter int LEN_W      = c_DEF_LEN_W,
   parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH,
   parameter int TIMEOUT    = c_DEF_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst,
   pelican_mac_sequencer_if.slave bus
);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
      $error("pelican_mac_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
   end

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;

   logic [W-1:0]     r_key;
   logic [LEN_W-1:0] r_nblk;
   logic [LEN_W-1:0] r_delivered;
   logic [LEN_W-1:0] w_delivered_inc;
   logic [W-1:0]     r_core_din;
   logic [W-1:0]     r_tag;
   logic             r_busy;
   logic             r_tag_valid;
   logic             r_err;
   logic             r_load_iv;

   logic             w_latch_cfg;
   logic             w_pop;
   logic             w_tag_cap;
   logic [1:0]       w_din_sel;
   logic             w_in_err;
   logic             w_msg_ready;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [W-1:0]     w_fifo_head;
   logic             w_timeout;

   assign w_in_err        = (r_state == S_ERR);
   assign w_msg_ready     = !w_fifo_full && !w_in_err;
   assign w_delivered_inc = r_delivered + LEN_W'(1);

   pelican_seq_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (bus.msg_valid && w_msg_ready),
      .i_pop   (w_pop),
      .i_flush (w_in_err),
      .i_wdata (bus.msg_data),
      .o_rdata (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

`ifdef PELICAN_SEQ_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT + 1);
   logic [c_TO_W-1:0] r_to_cnt;

   // Held at zero outside WAIT_DONE so it starts from 0 on entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (r_state != S_WAIT_DONE) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_to_cnt == c_TO_W'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM next state / control ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_latch_cfg = 1'b0;
      w_pop       = 1'b0;
      w_tag_cap   = 1'b0;
      w_din_sel   = c_DIN_HOLD;
      case (r_state)
         S_IDLE, S_ERR: begin
            if (bus.start) begin
               if (bus.cfg_nblk != '0) begin
                  w_latch_cfg = 1'b1;
                  w_din_sel   = c_DIN_IV;
                  w_state_nxt = S_IV;
               end else if (r_state == S_ERR) begin
                  // start clears the error even when the run itself is empty
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_IV: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            // RUN is left as soon as the last block goes out, so any done
            // seen here is premature
            if ((bus.core_load_k && bus.core_load_m) || bus.core_done) begin
               w_state_nxt = S_ERR;
            end else if (bus.core_load_k) begin
               w_din_sel = c_DIN_KEY;
            end else if (bus.core_load_m) begin
               if (w_fifo_empty) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_pop     = 1'b1;
                  w_din_sel = c_DIN_FIFO;
                  if (w_delivered_inc == r_nblk) begin
                     w_state_nxt = S_WAIT_DONE;
                  end
               end
            end
         end
         S_WAIT_DONE: begin
            if (bus.core_load_m) begin
               w_state_nxt = S_ERR;
            end else if (bus.core_done) begin
               w_tag_cap   = 1'b1;
               w_state_nxt = S_OUT;
            end else begin
               if (bus.core_load_k) begin
                  w_din_sel = c_DIN_KEY;
               end
               if (w_timeout) begin
                  w_state_nxt = S_ERR;
               end
            end
         end
         S_OUT: begin
            if (bus.tag_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------- datapath and registered outputs ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_key       <= '0;
         r_nblk      <= '0;
         r_delivered <= '0;
         r_core_din  <= '0;
         r_tag       <= '0;
         r_busy      <= 1'b0;
         r_tag_valid <= 1'b0;
         r_err       <= 1'b0;
         r_load_iv   <= 1'b0;
      end else begin
         r_busy      <= (w_state_nxt != S_IDLE);
         r_tag_valid <= (w_state_nxt == S_OUT);
         r_err       <= (w_state_nxt == S_ERR);
         r_load_iv   <= (w_state_nxt == S_IV);

         if (w_latch_cfg) begin
            r_key       <= bus.cfg_key;
            r_nblk      <= bus.cfg_nblk;
            r_delivered <= '0;
         end else if (w_pop) begin
            r_delivered <= w_delivered_inc;
         end

         case (w_din_sel)
            c_DIN_IV:   r_core_din <= bus.cfg_iv;
            c_DIN_KEY:  r_core_din <= r_key;
            c_DIN_FIFO: r_core_din <= w_fifo_head;
            default:    r_core_din <= r_core_din;
         endcase

         if (w_tag_cap) begin
            r_tag <= bus.core_dout;
         end
      end
   end

   assign bus.busy         = r_busy;
   assign bus.err          = r_err;
   assign bus.msg_ready    = w_msg_ready;
   assign bus.tag          = r_tag;
   assign bus.tag_valid    = r_tag_valid;
   assign bus.core_load_iv = r_load_iv;
   assign bus.core_din     = r_core_din;
   assign bus.core_rst     = rst | w_in_err;

endmodule
`default_nettype wire
